aoi_bist_ctrl: RTL and testbench
================================

# aoi_bist_ctrl

Built-in self-test sequencer for the 9-input AOI_4 gate block. It walks the AOI_4 inputs A..I through all 512 input combinations and waits a programmable settle time after each vector. It compresses the sampled Y output into a 16-bit MISR signature and compares that signature against a golden value. It sits beside the AOI_4 instance: its vector output drives the AOI_4 inputs through a test mux, and AOI_4 Y returns on `y_in`.

## Interface
- `SETTLE_CYCLES`, default 2: cycles each vector is held before Y is sampled; legal range 1..255.
- `POLY`, default 16'h1021: MISR feedback polynomial.
- `SEED`, default 16'hFFFF: MISR value loaded at start.
- `GOLDEN`, default 16'h0000: expected final signature for the AOI_4 under test.
- `clk` in 1: single clock; all state changes on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: run request; sampled high for one cycle in IDLE or DONE.
- `y_in` in 1: AOI_4 Y output.
- `vec_out` out 9: drives AOI_4 inputs; bit 8 = A, bit 0 = I.
- `busy` out 1: high in SETTLE and SAMPLE.
- `done` out 1: high in DONE; held until the next accepted start or reset.
- `pass` out 1: registered result of `signature == GOLDEN`; valid while `done` is high.
- `signature` out 16: current MISR contents.
- `stuck` out 1: present only with the macro in Configuration.

## Operation
- **Reset.** A cycle with `rst` high sets:
  - state to IDLE
  - `vec_out`, `busy`, `done`, `pass` and `stuck` to 0
  - `signature` to `SEED`
  - `rst` has priority over every other input.
- **IDLE or DONE, start high.**
  - `vec_out` ← 0, MISR ← `SEED`, settle counter ← `SETTLE_CYCLES`.
  - `done` ← 0 and `pass` ← 0.
  - Next state is SETTLE.
- **SETTLE.** Decrement the settle counter. Go to SAMPLE on the cycle the counter reaches 1. `vec_out` is stable throughout.
- **SAMPLE.** Update the MISR as follows:
  - `fb` = MISR[15] XOR `y_in`
  - MISR ← {MISR[14:0], 1'b0} XOR (`fb` ? `POLY` : 0)
  - If `vec_out` == 9'h1FF, go to DONE. Otherwise `vec_out` ← `vec_out` + 1, reload the settle counter, and go to SETTLE.
- **DONE.** `pass` ← (updated MISR == `GOLDEN`) on entry. `busy` 0, `done` 1. Stay in DONE until start or reset.
- **start while busy.** Ignored. The run is not restarted, and the request is not queued.
- **Wrap.** `vec_out` never wraps during a run; the run ends on 9'h1FF.
- **Reset mid-run.** Returns to IDLE with all reset values on the next edge. The partial signature is discarded.

## Timing
- start sampled at edge k: `busy` is high from edge k (registered).
- Each vector takes `SETTLE_CYCLES` + 1 cycles.
- `done` and `pass` become valid at edge k + 512 × (`SETTLE_CYCLES` + 1). Default: k + 1536.
- `y_in` is sampled only in SAMPLE, i.e. `SETTLE_CYCLES` full cycles after `vec_out` changed.
- All outputs are registered; there are no combinational paths from input to output.

## Configuration
- **With `AOI_BIST_STUCK_CHECK_EN` defined:**
  - Two sticky flags record whether Y = 0 and Y = 1 were each sampled during the run.
  - `stuck` is registered on entry to DONE and is high if either value was never seen.
  - When `stuck` is high, `pass` is forced to 0.
  - The flags clear on reset and on an accepted start.
- **Without the macro:** the `stuck` port and the flags are not present; `pass` depends on the signature only.

## Structure
- **Package `aoi_bist_pkg`:**
  - state enum {IDLE, SETTLE, SAMPLE, DONE}
  - `VEC_W` = 9, `SIG_W` = 16, `LAST_VEC` = 9'h1FF
  - default `POLY` and `SEED` constants
- **Sub-module `aoi_misr16`:** ports `clk`, `rst`, `load`, `seed`, `shift_en`, `din`, `sig`, plus a `POLY` parameter.
- The controller top holds the FSM, the vector counter and the settle counter.

## Test plan
- **Reset.** Assert `rst` for 2 cycles → `vec_out` = 0, `busy` = 0, `done` = 0, `pass` = 0, `signature` = 16'hFFFF.
- **Run latency.** `SETTLE_CYCLES` = 2, one start pulse → `vec_out` steps 0..511, each value held exactly 3 cycles. `done` rises exactly 1536 cycles after the start edge, then `busy` = 0.
- **Signature check.**
  - Connect a behavioural AOI_4 model; set `GOLDEN` to the bench model's signature.
  - Expect `pass` = 1.
  - Flip `y_in` on vector 9'h0A5 only → `pass` = 0 and `signature` ≠ `GOLDEN`.
- **Start while busy.** Pulse start at vector 100 → no restart; `done` still at 1536 cycles.
- **Reset mid-run.** Assert `rst` at vector 300 → next edge IDLE with `vec_out` = 0. A new start then completes normally with `pass` = 1.
- **Stuck detect (macro defined).** Tie `y_in` = 0 → `stuck` = 1 and `pass` = 0 at `done`, even when `GOLDEN` equals the all-zero-input signature.

Source files
------------

// File: rtl/aoi_bist_pkg.sv
// Shared types, widths and the MISR step function for the AOI_4 BIST controller.
// Used by aoi_misr16 and aoi_bist_ctrl.
package aoi_bist_pkg;

  localparam int unsigned VEC_W = 9;
  localparam int unsigned SIG_W = 16;

  localparam logic [VEC_W-1:0] LAST_VEC     = 9'h1FF;
  localparam logic [SIG_W-1:0] DEFAULT_POLY = 16'h1021;
  localparam logic [SIG_W-1:0] DEFAULT_SEED = 16'hFFFF;

  typedef enum logic [1:0] {
    StIdle,
    StSettle,
    StSample,
    StDone
  } state_e;

  // One MISR shift: feedback is the outgoing MSB folded with the new input bit.
  function automatic logic [SIG_W-1:0] misr_step(input logic [SIG_W-1:0] sig,
                                                 input logic             din,
                                                 input logic [SIG_W-1:0] poly);
    logic fb;
    fb = sig[SIG_W-1] ^ din;
    return {sig[SIG_W-2:0], 1'b0} ^ (fb ? poly : '0);
  endfunction

endpackage

// File: rtl/aoi_misr16.sv
// 16-bit single-input MISR that compacts sampled AOI_4 Y values into a signature.
module aoi_misr16
  import aoi_bist_pkg::*;
#(
  parameter logic [SIG_W-1:0] POLY = DEFAULT_POLY
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [SIG_W-1:0] seed,
  input  logic             shift_en,
  input  logic             din,
  output logic [SIG_W-1:0] sig
);

  logic [SIG_W-1:0] sig_q;

  always_ff @(posedge clk) begin
    if (rst || load) begin
      sig_q <= seed;
    end else if (shift_en) begin
      sig_q <= misr_step(sig_q, din, POLY);
    end
  end

  assign sig = sig_q;

endmodule

// File: rtl/aoi_bist_ctrl.sv
// BIST sequencer for the 9-input AOI_4: walks all 512 vectors, compacts Y into a MISR and
// compares against GOLDEN. Optional stuck-output detection with AOI_BIST_STUCK_CHECK_EN.
module aoi_bist_ctrl
  import aoi_bist_pkg::*;
#(
  parameter int unsigned      SETTLE_CYCLES = 2,
  parameter logic [SIG_W-1:0] POLY          = DEFAULT_POLY,
  parameter logic [SIG_W-1:0] SEED          = DEFAULT_SEED,
  parameter logic [SIG_W-1:0] GOLDEN        = 16'h0000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             y_in,
  output logic [VEC_W-1:0] vec_out,
  output logic             busy,
  output logic             done,
  output logic             pass,
`ifdef AOI_BIST_STUCK_CHECK_EN
  output logic             stuck,
`endif
  output logic [SIG_W-1:0] signature
);

  localparam logic [7:0] SettleLoad = SETTLE_CYCLES[7:0];

  state_e           state_q, state_d;
  logic [VEC_W-1:0] vec_q, vec_d;
  logic [7:0]       cnt_q, cnt_d;
  logic             pass_q, pass_d;
  logic             misr_load, misr_shift;
  logic [SIG_W-1:0] sig_next;

`ifdef AOI_BIST_STUCK_CHECK_EN
  logic seen0_q, seen0_d;
  logic seen1_q, seen1_d;
  logic stuck_q, stuck_d;
`endif

  always_comb begin
    state_d    = state_q;
    vec_d      = vec_q;
    cnt_d      = cnt_q;
    pass_d     = pass_q;
    misr_load  = 1'b0;
    misr_shift = 1'b0;
    // Signature as it will be after this cycle's sample, so pass can be registered on entry.
    sig_next   = misr_step(signature, y_in, POLY);
`ifdef AOI_BIST_STUCK_CHECK_EN
    seen0_d    = seen0_q;
    seen1_d    = seen1_q;
    stuck_d    = stuck_q;
`endif
    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d   = StSettle;
          vec_d     = '0;
          cnt_d     = SettleLoad;
          pass_d    = 1'b0;
          misr_load = 1'b1;
`ifdef AOI_BIST_STUCK_CHECK_EN
          seen0_d   = 1'b0;
          seen1_d   = 1'b0;
          stuck_d   = 1'b0;
`endif
        end
      end
      StSettle: begin
        cnt_d = cnt_q - 8'd1;
        if (cnt_q == 8'd1) begin
          state_d = StSample;
        end
      end
      StSample: begin
        misr_shift = 1'b1;
`ifdef AOI_BIST_STUCK_CHECK_EN
        seen0_d = seen0_q | ~y_in;
        seen1_d = seen1_q | y_in;
`endif
        if (vec_q == LAST_VEC) begin
          state_d = StDone;
`ifdef AOI_BIST_STUCK_CHECK_EN
          stuck_d = ~(seen0_d & seen1_d);
          pass_d  = (sig_next == GOLDEN) && !stuck_d;
`else
          pass_d  = (sig_next == GOLDEN);
`endif
        end else begin
          state_d = StSettle;
          vec_d   = vec_q + VEC_W'(1);
          cnt_d   = SettleLoad;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      vec_q   <= '0;
      cnt_q   <= '0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      cnt_q   <= cnt_d;
      pass_q  <= pass_d;
    end
  end

`ifdef AOI_BIST_STUCK_CHECK_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      seen0_q <= 1'b0;
      seen1_q <= 1'b0;
      stuck_q <= 1'b0;
    end else begin
      seen0_q <= seen0_d;
      seen1_q <= seen1_d;
      stuck_q <= stuck_d;
    end
  end

  assign stuck = stuck_q;
`endif

  aoi_misr16 #(
    .POLY(POLY)
  ) u_misr (
    .clk      (clk),
    .rst      (rst),
    .load     (misr_load),
    .seed     (SEED),
    .shift_en (misr_shift),
    .din      (y_in),
    .sig      (signature)
  );

  assign vec_out = vec_q;
  assign busy    = (state_q == StSettle) || (state_q == StSample);
  assign done    = (state_q == StDone);
  assign pass    = pass_q;

endmodule

// File: tb/tb_aoi_bist_ctrl.sv
// Directed self-checking bench for aoi_bist_ctrl with a behavioural AOI_4 on y_in.
module tb_aoi_bist_ctrl;

  // Behavioural AOI_4: Y = ~(A&B | C&D | E&F | G&H&I), A = bit 8.
  function automatic logic aoi_y(input logic [8:0] v);
    return ~((v[8] & v[7]) | (v[6] & v[5]) | (v[4] & v[3]) | (v[2] & v[1] & v[0]));
  endfunction

  function automatic logic [15:0] model_sig(input logic flip, input logic tie0);
    logic [15:0] s;
    logic [8:0]  vv;
    logic        y;
    logic        fb;
    s = 16'hFFFF;
    for (int v = 0; v < 512; v++) begin
      vv = v[8:0];
      y  = tie0 ? 1'b0 : (aoi_y(vv) ^ (flip && (vv == 9'h0A5)));
      fb = s[15] ^ y;
      s  = {s[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
    end
    return s;
  endfunction

  localparam logic [15:0] GOLD      = model_sig(1'b0, 1'b0);
  localparam logic [15:0] GOLD_FLIP = model_sig(1'b1, 1'b0);
  localparam int          RUN_LEN   = 1536;

  logic        clk;
  logic        rst;
  logic        start;
  logic        flip_en;
  logic        y_in;
  logic [8:0]  vec_out;
  logic        busy;
  logic        done;
  logic        pass;
  logic [15:0] signature;

  int checks;
  int errors;

  assign y_in = aoi_y(vec_out) ^ (flip_en && (vec_out == 9'h0A5));

`ifdef AOI_BIST_STUCK_CHECK_EN
  localparam logic [15:0] GOLD_ZERO = model_sig(1'b0, 1'b1);
  logic        stuck;
  logic [8:0]  vec_z;
  logic        busy_z, done_z, pass_z, stuck_z;
  logic [15:0] sig_z;

  aoi_bist_ctrl #(
    .SETTLE_CYCLES (2),
    .POLY          (16'h1021),
    .SEED          (16'hFFFF),
    .GOLDEN        (GOLD_ZERO)
  ) dut_z (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .y_in      (1'b0),
    .vec_out   (vec_z),
    .busy      (busy_z),
    .done      (done_z),
    .pass      (pass_z),
    .stuck     (stuck_z),
    .signature (sig_z)
  );
`endif

  aoi_bist_ctrl #(
    .SETTLE_CYCLES (2),
    .POLY          (16'h1021),
    .SEED          (16'hFFFF),
    .GOLDEN        (GOLD)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .y_in      (y_in),
    .vec_out   (vec_out),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
`ifdef AOI_BIST_STUCK_CHECK_EN
    .stuck     (stuck),
`endif
    .signature (signature)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench #1 after the edge that accepted start.
  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(input int already, output int n);
    n = already;
    while (!done && n < 2000) begin
      step();
      n++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b0;
    step();
    step();
    checks += 5;
    if (vec_out !== 9'h000) begin errors++; $display("FAIL reset_vec got %h want 000", vec_out); end
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
    if (pass !== 1'b0) begin errors++; $display("FAIL reset_pass got %b want 0", pass); end
    if (signature !== 16'hFFFF) begin
      errors++; $display("FAIL reset_sig got %h want ffff", signature);
    end
`ifdef AOI_BIST_STUCK_CHECK_EN
    checks++;
    if (stuck !== 1'b0) begin errors++; $display("FAIL reset_stuck got %b want 0", stuck); end
`endif
    rst = 1'b0;
    step();
  endtask

  task automatic test_run_latency();
    pulse_start();
    for (int i = 0; i < RUN_LEN; i++) begin
      checks += 3;
      if (vec_out !== 9'(i / 3)) begin
        errors++; $display("FAIL run_vec cycle %0d got %h want %h", i, vec_out, 9'(i / 3));
      end
      if (busy !== 1'b1) begin errors++; $display("FAIL run_busy cycle %0d got %b want 1", i, busy); end
      if (done !== 1'b0) begin errors++; $display("FAIL run_done cycle %0d got %b want 0", i, done); end
      step();
    end
    checks += 4;
    if (done !== 1'b1) begin errors++; $display("FAIL latency_done got %b want 1", done); end
    if (busy !== 1'b0) begin errors++; $display("FAIL latency_busy got %b want 0", busy); end
    if (pass !== 1'b1) begin errors++; $display("FAIL golden_pass got %b want 1", pass); end
    if (signature !== GOLD) begin
      errors++; $display("FAIL golden_sig got %h want %h", signature, GOLD);
    end
`ifdef AOI_BIST_STUCK_CHECK_EN
    checks++;
    if (stuck !== 1'b0) begin errors++; $display("FAIL golden_stuck got %b want 0", stuck); end
`endif
  endtask

  task automatic test_signature_flip();
    int n;
    flip_en = 1'b1;
    pulse_start();
    checks += 3;
    if (done !== 1'b0) begin errors++; $display("FAIL restart_done got %b want 0", done); end
    if (pass !== 1'b0) begin errors++; $display("FAIL restart_pass got %b want 0", pass); end
    if (signature !== 16'hFFFF) begin
      errors++; $display("FAIL restart_seed got %h want ffff", signature);
    end
    wait_done(0, n);
    checks += 4;
    if (n != RUN_LEN) begin errors++; $display("FAIL flip_latency got %0d want %0d", n, RUN_LEN); end
    if (pass !== 1'b0) begin errors++; $display("FAIL flip_pass got %b want 0", pass); end
    if (signature === GOLD) begin
      errors++; $display("FAIL flip_sig_ne got %h want not %h", signature, GOLD);
    end
    if (signature !== GOLD_FLIP) begin
      errors++; $display("FAIL flip_sig got %h want %h", signature, GOLD_FLIP);
    end
    flip_en = 1'b0;
  endtask

  task automatic test_start_while_busy();
    int n;
    pulse_start();
    for (int i = 0; i < 300; i++) step();
    checks++;
    if (vec_out !== 9'd100) begin errors++; $display("FAIL busy_pre_vec got %h want 064", vec_out); end
    start = 1'b1;
    step();
    start = 1'b0;
    checks += 2;
    if (vec_out !== 9'd100) begin errors++; $display("FAIL busy_post_vec got %h want 064", vec_out); end
    if (busy !== 1'b1) begin errors++; $display("FAIL busy_post_busy got %b want 1", busy); end
    wait_done(301, n);
    checks += 2;
    if (n != RUN_LEN) begin errors++; $display("FAIL busy_latency got %0d want %0d", n, RUN_LEN); end
    if (pass !== 1'b1) begin errors++; $display("FAIL busy_pass got %b want 1", pass); end
  endtask

  task automatic test_reset_mid_run();
    int n;
    pulse_start();
    for (int i = 0; i < 900; i++) step();
    checks++;
    if (vec_out !== 9'd300) begin errors++; $display("FAIL mid_pre_vec got %h want 12c", vec_out); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks += 4;
    if (vec_out !== 9'h000) begin errors++; $display("FAIL mid_vec got %h want 000", vec_out); end
    if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy got %b want 0", busy); end
    if (done !== 1'b0) begin errors++; $display("FAIL mid_done got %b want 0", done); end
    if (signature !== 16'hFFFF) begin
      errors++; $display("FAIL mid_sig got %h want ffff", signature);
    end
    step();
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL mid_idle_busy got %b want 0", busy); end
    pulse_start();
    wait_done(0, n);
    checks += 3;
    if (n != RUN_LEN) begin errors++; $display("FAIL mid_latency got %0d want %0d", n, RUN_LEN); end
    if (pass !== 1'b1) begin errors++; $display("FAIL mid_pass got %b want 1", pass); end
    if (signature !== GOLD) begin
      errors++; $display("FAIL mid_sig_final got %h want %h", signature, GOLD);
    end
  endtask

`ifdef AOI_BIST_STUCK_CHECK_EN
  task automatic test_stuck();
    int n;
    pulse_start();
    n = 0;
    while (!done_z && n < 2000) begin
      step();
      n++;
    end
    checks += 4;
    if (n != RUN_LEN) begin errors++; $display("FAIL stuck_latency got %0d want %0d", n, RUN_LEN); end
    if (stuck_z !== 1'b1) begin errors++; $display("FAIL stuck_flag got %b want 1", stuck_z); end
    if (pass_z !== 1'b0) begin errors++; $display("FAIL stuck_pass got %b want 0", pass_z); end
    if (sig_z !== GOLD_ZERO) begin
      errors++; $display("FAIL stuck_sig got %h want %h", sig_z, GOLD_ZERO);
    end
  endtask
`endif

  initial begin
    checks  = 0;
    errors  = 0;
    rst     = 1'b1;
    start   = 1'b0;
    flip_en = 1'b0;
    test_reset();
    test_run_latency();
    test_signature_flip();
    test_start_while_busy();
    test_reset_mid_run();
`ifdef AOI_BIST_STUCK_CHECK_EN
    test_stuck();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
